alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor to the processor's combinational 8-bit accumulator ALU.
- Executes the same R-type and I-type op set at WIDTH bits, with registered result and flags.
- Adds an internal carry register in place of an external carry-in.
- Adds an extended op class of iterative multiply/divide, run as multi-cycle ops behind a valid/ready handshake.
- Sits between register-file read and writeback; the control unit stalls on in_ready low.

Parameters:
- WIDTH, 8: datapath width in bits (min 4).
- IMM_W, 5: immediate width; must be less than WIDTH; zero-extended to WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept an operation; high only in IDLE.
- acc  in  WIDTH  accumulator operand.
- op_reg  in  WIDTH  register operand.
- imm  in  IMM_W  immediate operand.
- type_code  in  1  0 = R-type, 1 = I-type.
- ext_op  in  1  1 = extended multi-cycle op; overrides type_code.
- r_op  in  4  R-type funct, or extended funct when ext_op = 1.
- i_op  in  3  I-type funct.
- sc_clr  in  1  synchronous clear of the carry register.
- out_valid  out  1  one-cycle pulse: rslt and flags are new.
- rslt  out  WIDTH  registered result; holds until the next result.
- sc_out  out  1  carry register / divide-by-zero flag.
- zero  out  1  registered (rslt == 0) for the current rslt.
- branch  out  1  registered branch decision, valid with out_valid.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (asynchronous on reset_n low):
  - rslt = 0, sc_out = 0, zero = 1, branch = 0, out_valid = 0, busy = 0.
  - State goes to IDLE; in_ready = 1 on reset release.
- Accept: the op is accepted on a rising edge with in_valid && in_ready. Operands are sampled on that edge only.
- States: IDLE, ITER, DONE.
- Single-cycle ops (ext_op = 0):
  - IDLE -> IDLE.
  - rslt, zero and branch register on the accept edge; out_valid is high in the following cycle (latency 1).
  - Back-to-back accepts are allowed every cycle.
- R-type ops (r_op):
  - 0 ADD: {c, rslt} = acc + op_reg + sc, computed in WIDTH+1 bits, operands zero-extended.
  - 1 SUB: {c, rslt} = acc - op_reg + sc, same width rule; c = bit WIDTH of the result.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 RXOR: rslt = zero-extended ^op_reg.
  - 6 SLR: rslt = acc << op_reg. 7 SRR: logical acc >> op_reg. For either, a shift amount >= WIDTH gives 0.
  - 8 LW, 9 SW, 15 LA: rslt = op_reg.
  - 10 EQ: rslt = (acc == op_reg).
  - 11 SLT: rslt = (acc < op_reg), signed compare.
  - 12 BR: branch = (acc == 1); rslt = 0.
  - 13 J: branch = 1; rslt = 0.
  - 14 SET: rslt = acc.
- I-type ops (i_op, imm zero-extended):
  - 0 ADDI, 1 SUBI: as ADD/SUB, including carry.
  - 2 ANDI.
  - 3 SLL, 4 SRL: shift by imm, same >= WIDTH rule as SLR/SRR.
  - 5 SETI, 7 LUTA: rslt = imm.
  - 6: rslt = 0.
- branch is 0 for every op except BR and J.
- Carry register sc:
  - Updated only by ADD, SUB, ADDI and SUBI (to c), and by the divide-by-zero case below. Every other op leaves it unchanged.
  - sc_clr forces sc = 0 at the edge and has priority over an accepting op's carry update; the op still executes, using the old sc as carry-in.
- Extended ops (ext_op = 1; r_op 0 MULL, 1 MULH, 2 DIVU, 3 REMU, others give rslt = 0 single-cycle):
  - MULL / MULH: unsigned; rslt = low / high WIDTH bits of the 2*WIDTH product.
  - DIVU / REMU: unsigned quotient / remainder.
  - Accept edge: IDLE -> ITER; operands are latched, busy = 1, in_ready = 0.
  - ITER: one shift-add or restoring-subtract step per cycle for exactly WIDTH cycles, then -> DONE.
  - DONE: rslt, zero and flags register; out_valid pulses in the next cycle; -> IDLE.
  - Latency from accept edge to out_valid = WIDTH+2 cycles. in_ready returns high the cycle out_valid is high.
  - Divide by zero (op_reg = 0): still WIDTH iterations. DIVU gives rslt = all ones; REMU gives rslt = acc; sc = 1.
  - No other extended op changes sc.
- in_valid while busy is ignored; the op is not queued.
- Reset mid-ITER aborts the op: no out_valid, state cleared.
- sc_clr during ITER clears sc immediately; the divide-by-zero set at DONE still applies.

Test Plan:
- Reset, then ADD acc = 0xFF, op_reg = 0x01, sc = 0 -> next cycle out_valid = 1, rslt = 0x00, zero = 1, sc_out = 1. Then ADD 0x01 + 0x01 -> rslt = 0x03 (carry-in used), sc_out = 0.
- SLT acc = 0x80, op_reg = 0x01 -> rslt = 1. SRR acc = 0xF0, op_reg = 9 -> rslt = 0x00. BR acc = 1 -> branch = 1; BR acc = 2 -> branch = 0.
- MULH acc = 0xFF, op_reg = 0xFF (WIDTH = 8) -> in_ready low 9 cycles, out_valid 10 cycles after accept, rslt = 0xFE. MULL of the same operands -> rslt = 0x01.
- DIVU 200 / 7 -> rslt = 28; REMU -> rslt = 4. DIVU 0x35 / 0 -> rslt = 0xFF, sc_out = 1. in_valid held high during ITER -> only one op executes.
- reset_n low at ITER cycle 3 -> all outputs at reset values, no out_valid. First op after release completes normally.
- WIDTH = 16, IMM_W = 5: SUBI acc = 0x0000, imm = 1, sc = 0 -> rslt = 0xFFFF, sc_out = 1. Same op with sc_clr = 1 at accept -> result identical, sc_out = 0.

Source files
------------

// File: rtl/alu_seq.sv
// Registered accumulator ALU with a carry register and iterative multiply/divide.
// Single-cycle ops complete on the accept edge; extended ops run WIDTH shift steps.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int IMM_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] op_reg,
  input  logic [IMM_W-1:0] imm,
  input  logic             type_code,
  input  logic             ext_op,
  input  logic [3:0]       r_op,
  input  logic [2:0]       i_op,
  input  logic             sc_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_out,
  output logic             zero,
  output logic             branch,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] iterCnt;
  logic [WIDTH-1:0] workHi;
  logic [WIDTH-1:0] workLo;
  logic [WIDTH-1:0] operand;
  logic [1:0]       extFunct;
  logic             sc;

  logic [WIDTH-1:0] immExt;
  logic [WIDTH-1:0] aluB;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subDiff;
  logic [WIDTH-1:0] nextRslt;
  logic             nextBranch;
  logic             carryUpd;
  logic             carryVal;
  logic             isMulti;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] divDiff;
  logic [WIDTH-1:0] extResult;

  function automatic logic [WIDTH-1:0] shiftLeft(input logic [WIDTH-1:0] value,
                                                 input logic [WIDTH-1:0] amount);
    if (amount >= WIDTH_VAL) return '0;
    return value << amount;
  endfunction

  function automatic logic [WIDTH-1:0] shiftRight(input logic [WIDTH-1:0] value,
                                                  input logic [WIDTH-1:0] amount);
    if (amount >= WIDTH_VAL) return '0;
    return value >> amount;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign sc_out   = sc;
  assign isMulti  = ext_op && (r_op[3:2] == 2'b00);

  assign immExt  = WIDTH'(imm);
  assign aluB    = type_code ? immExt : op_reg;
  assign addSum  = {1'b0, acc} + {1'b0, aluB} + {{WIDTH{1'b0}}, sc};
  assign subDiff = {1'b0, acc} - {1'b0, aluB} + {{WIDTH{1'b0}}, sc};

  // One step of shift-add multiply and of restoring divide; only one is committed per cycle.
  assign mulSum    = {1'b0, workHi} + (workLo[0] ? {1'b0, operand} : '0);
  assign divShift  = {workHi, workLo[WIDTH-1]};
  assign divFits   = divShift >= {1'b0, operand};
  assign divDiff   = divShift[WIDTH-1:0] - operand;
  assign extResult = extFunct[0] ? workHi : workLo;

  always_comb begin
    nextRslt   = '0;
    nextBranch = 1'b0;
    carryUpd   = 1'b0;
    carryVal   = addSum[WIDTH];
    if (ext_op) begin
      nextRslt = '0;
    end else if (!type_code) begin
      case (r_op)
        4'd0: begin nextRslt = addSum[WIDTH-1:0];  carryVal = addSum[WIDTH];  carryUpd = 1'b1; end
        4'd1: begin nextRslt = subDiff[WIDTH-1:0]; carryVal = subDiff[WIDTH]; carryUpd = 1'b1; end
        4'd2: nextRslt = acc & op_reg;
        4'd3: nextRslt = acc | op_reg;
        4'd4: nextRslt = acc ^ op_reg;
        4'd5: nextRslt = WIDTH'(^op_reg);
        4'd6: nextRslt = shiftLeft(acc, op_reg);
        4'd7: nextRslt = shiftRight(acc, op_reg);
        4'd8, 4'd9, 4'd15: nextRslt = op_reg;
        4'd10: nextRslt = WIDTH'(acc == op_reg);
        4'd11: nextRslt = WIDTH'($signed(acc) < $signed(op_reg));
        4'd12: nextBranch = (acc == WIDTH'(1));
        4'd13: nextBranch = 1'b1;
        4'd14: nextRslt = acc;
      endcase
    end else begin
      case (i_op)
        3'd0: begin nextRslt = addSum[WIDTH-1:0];  carryVal = addSum[WIDTH];  carryUpd = 1'b1; end
        3'd1: begin nextRslt = subDiff[WIDTH-1:0]; carryVal = subDiff[WIDTH]; carryUpd = 1'b1; end
        3'd2: nextRslt = acc & immExt;
        3'd3: nextRslt = shiftLeft(acc, immExt);
        3'd4: nextRslt = shiftRight(acc, immExt);
        3'd5, 3'd7: nextRslt = immExt;
        3'd6: nextRslt = '0;
      endcase
    end
  end

  // Multiply keeps the product in {workHi, workLo}; divide keeps remainder/quotient there.
  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      iterCnt   <= '0;
      workHi    <= '0;
      workLo    <= '0;
      operand   <= '0;
      extFunct  <= '0;
      sc        <= 1'b0;
      rslt      <= '0;
      zero      <= 1'b1;
      branch    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sc_clr) sc <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (isMulti) begin
              state    <= ITER;
              iterCnt  <= '0;
              extFunct <= r_op[1:0];
              workHi   <= '0;
              if (!r_op[1]) begin
                workLo  <= op_reg;
                operand <= acc;
              end else begin
                workLo  <= acc;
                operand <= op_reg;
              end
            end else begin
              rslt      <= nextRslt;
              zero      <= (nextRslt == '0);
              branch    <= nextBranch;
              out_valid <= 1'b1;
              if (carryUpd && !sc_clr) sc <= carryVal;
            end
          end
        end
        ITER: begin
          if (!extFunct[1]) begin
            workHi <= mulSum[WIDTH:1];
            workLo <= {mulSum[0], workLo[WIDTH-1:1]};
          end else begin
            workHi <= divFits ? divDiff : divShift[WIDTH-1:0];
            workLo <= {workLo[WIDTH-2:0], divFits};
          end
          if (iterCnt == LAST_ITER) state <= DONE;
          else iterCnt <= iterCnt + 1'b1;
        end
        DONE: begin
          rslt      <= extResult;
          zero      <= (extResult == '0);
          branch    <= 1'b0;
          out_valid <= 1'b1;
          state     <= IDLE;
          if (extFunct[1] && (operand == '0) && !sc_clr) sc <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed checks of alu_seq at WIDTH 8 and 16 against an arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] acc = '0;
  logic [15:0] opReg = '0;
  logic [4:0]  imm = '0;
  logic        typeCode = 1'b0;
  logic        extOp = 1'b0;
  logic        scClr = 1'b0;
  logic        validA = 1'b0;
  logic        validB = 1'b0;
  logic [3:0]  rOp = '0;
  logic [2:0]  iOp = '0;

  logic        readyA, outValidA, scA, zeroA, branchA, busyA;
  logic [7:0]  rsltA;
  logic        readyB, outValidB, scB, zeroB, branchB, busyB;
  logic [15:0] rsltB;

  int          vectors = 0;
  int          miscompares = 0;
  bit          expSc [2] = '{1'b0, 1'b0};
  logic [63:0] expRslt;
  logic        expBr;
  int          expLat;
  int          expLow;

  alu_seq #(.WIDTH(8), .IMM_W(5)) dutA (
    .clk(clk), .reset_n(reset_n), .in_valid(validA), .in_ready(readyA),
    .acc(acc[7:0]), .op_reg(opReg[7:0]), .imm(imm), .type_code(typeCode),
    .ext_op(extOp), .r_op(rOp), .i_op(iOp), .sc_clr(scClr),
    .out_valid(outValidA), .rslt(rsltA), .sc_out(scA), .zero(zeroA),
    .branch(branchA), .busy(busyA)
  );

  alu_seq #(.WIDTH(16), .IMM_W(5)) dutB (
    .clk(clk), .reset_n(reset_n), .in_valid(validB), .in_ready(readyB),
    .acc(acc), .op_reg(opReg), .imm(imm), .type_code(typeCode),
    .ext_op(extOp), .r_op(rOp), .i_op(iOp), .sc_clr(scClr),
    .out_valid(outValidB), .rslt(rsltB), .sc_out(scB), .zero(zeroB),
    .branch(branchB), .busy(busyB)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] obsRslt(input int w);
    return (w == 8) ? {56'd0, rsltA} : {48'd0, rsltB};
  endfunction

  // {busy, outValid, ready, sc, zero, branch}
  function automatic logic [5:0] obsFlags(input int w);
    return (w == 8) ? {busyA, outValidA, readyA, scA, zeroA, branchA}
                    : {busyB, outValidB, readyB, scB, zeroB, branchB};
  endfunction

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Result of one op computed directly from the op definitions with wide integer arithmetic.
  function automatic void refModel(input int w, input bit ext, input bit tc,
                                   input logic [3:0] r, input logic [2:0] i,
                                   input longint a, input longint b, input longint im,
                                   input bit cin, output longint res, output bit cout,
                                   output bit upd, output bit br);
    longint mask = (longint'(1) << w) - 1;
    longint t, sa, sb, opnd;
    int code;
    res = 0; cout = 1'b0; upd = 1'b0; br = 1'b0;
    if (ext) begin
      case (r)
        4'd0: res = (a * b) & mask;
        4'd1: res = ((a * b) >> w) & mask;
        4'd2: begin res = (b == 0) ? mask : a / b; upd = (b == 0); cout = 1'b1; end
        4'd3: begin res = (b == 0) ? a : a % b;    upd = (b == 0); cout = 1'b1; end
        default: res = 0;
      endcase
      return;
    end
    if (!tc) begin
      code = int'(r);
      opnd = b;
    end else begin
      opnd = im;
      case (i)
        3'd0: code = 0;
        3'd1: code = 1;
        3'd2: code = 2;
        3'd3: code = 6;
        3'd4: code = 7;
        3'd6: code = 16;
        default: code = 8;
      endcase
    end
    sa = (a > mask / 2) ? a - (mask + 1) : a;
    sb = (opnd > mask / 2) ? opnd - (mask + 1) : opnd;
    case (code)
      0: begin t = a + opnd + longint'(cin); res = t & mask; cout = t[w]; upd = 1'b1; end
      1: begin t = a - opnd + longint'(cin); res = t & mask; cout = t[w]; upd = 1'b1; end
      2: res = a & opnd;
      3: res = a | opnd;
      4: res = a ^ opnd;
      5: res = longint'($countones(opnd) % 2);
      6: res = (opnd >= w) ? 0 : (a << opnd) & mask;
      7: res = (opnd >= w) ? 0 : a >> opnd;
      8, 9, 15: res = opnd;
      10: res = (a == opnd) ? 1 : 0;
      11: res = (sa < sb) ? 1 : 0;
      12: br = (a == 1);
      13: br = 1'b1;
      14: res = a;
      default: res = 0;
    endcase
  endfunction

  task automatic launch(input int w, input bit ext, input bit tc, input logic [3:0] r,
                        input logic [2:0] i, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] im, input bit clr, input bit hold);
    int idx = (w == 8) ? 0 : 1;
    longint mask = (longint'(1) << w) - 1;
    bit multi = ext && (r < 4'd4);
    longint res;
    bit cout, upd, br;
    acc = a; opReg = b; imm = im; extOp = ext; typeCode = tc; rOp = r; iOp = i; scClr = clr;
    if (w == 8) validA = 1'b1; else validB = 1'b1;
    refModel(w, ext, tc, r, i, longint'(a) & mask, longint'(b) & mask, longint'(im),
             expSc[idx], res, cout, upd, br);
    expRslt = res;
    expBr   = br;
    expLat  = multi ? w + 2 : 1;
    expLow  = multi ? w + 1 : 0;
    if (multi) begin
      if (clr) expSc[idx] = 1'b0;
      if (upd) expSc[idx] = 1'b1;
    end else if (clr) expSc[idx] = 1'b0;
    else if (upd) expSc[idx] = cout;
    @(posedge clk);
    #1;
    scClr = 1'b0;
    if (!hold) begin
      validA = 1'b0;
      validB = 1'b0;
      acc    = 16'($urandom);
      opReg  = 16'($urandom);
    end
  endtask

  task automatic checkOutput(input int w, input string tag);
    logic [5:0] f = obsFlags(w);
    int idx = (w == 8) ? 0 : 1;
    expectEq({tag, "_rslt"},   obsRslt(w), expRslt);
    expectEq({tag, "_zero"},   64'(f[1]), 64'(expRslt == '0));
    expectEq({tag, "_branch"}, 64'(f[0]), 64'(expBr));
    expectEq({tag, "_sc"},     64'(f[2]), 64'(expSc[idx]));
  endtask

  task automatic awaitResult(input int w, input string tag);
    int cyc = 0;
    int low = 0;
    bit got = 1'b0;
    logic [5:0] f;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      f = obsFlags(w);
      if (!f[3]) low++;
      if (f[4]) got = 1'b1;
    end
    validA = 1'b0;
    validB = 1'b0;
    expectEq({tag, "_latency"},  64'(cyc), 64'(expLat));
    expectEq({tag, "_readyLow"}, 64'(low), 64'(expLow));
    checkOutput(w, tag);
  endtask

  task automatic applyStimulus(input int w, input bit ext, input bit tc, input logic [3:0] r,
                               input logic [2:0] i, input logic [15:0] a, input logic [15:0] b,
                               input logic [4:0] im, input bit clr, input string tag);
    launch(w, ext, tc, r, i, a, b, im, clr, 1'b0);
    awaitResult(w, tag);
  endtask

  task automatic expectPlan(input int w, input string tag, input logic [63:0] r, input bit sc);
    logic [5:0] f = obsFlags(w);
    expectEq({tag, "_planRslt"}, obsRslt(w), r);
    expectEq({tag, "_planSc"},   64'(f[2]), 64'(sc));
  endtask

  task automatic checkQuiet(input int w, input int n, input string tag);
    int pulses = 0;
    logic [5:0] f;
    repeat (n) begin
      @(negedge clk);
      f = obsFlags(w);
      if (f[4]) pulses++;
    end
    expectEq(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    bit ext;
    int w;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    expectEq("resetA_rslt",  obsRslt(8), 64'd0);
    expectEq("resetA_flags", 64'(obsFlags(8)), 64'b001010);
    expectEq("resetB_rslt",  obsRslt(16), 64'd0);
    expectEq("resetB_flags", 64'(obsFlags(16)), 64'b001010);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(8, 0, 0, 4'd0, 3'd0, 16'h00FF, 16'h0001, 5'd0, 0, "add_ff_01");
    expectPlan(8, "add_ff_01", 64'h00, 1'b1);
    applyStimulus(8, 0, 0, 4'd0, 3'd0, 16'h0001, 16'h0001, 5'd0, 0, "add_carryIn");
    expectPlan(8, "add_carryIn", 64'h03, 1'b0);
    applyStimulus(8, 0, 0, 4'd11, 3'd0, 16'h0080, 16'h0001, 5'd0, 0, "slt_signed");
    expectPlan(8, "slt_signed", 64'h01, 1'b0);
    applyStimulus(8, 0, 0, 4'd7, 3'd0, 16'h00F0, 16'h0009, 5'd0, 0, "srr_overshift");
    applyStimulus(8, 0, 0, 4'd6, 3'd0, 16'h0081, 16'h0008, 5'd0, 0, "slr_eqWidth");
    applyStimulus(8, 0, 0, 4'd6, 3'd0, 16'h0081, 16'h0007, 5'd0, 0, "slr_7");
    applyStimulus(8, 0, 0, 4'd12, 3'd0, 16'h0001, 16'h0000, 5'd0, 0, "br_taken");
    expectEq("br_taken_plan", 64'(branchA), 64'd1);
    applyStimulus(8, 0, 0, 4'd12, 3'd0, 16'h0002, 16'h0000, 5'd0, 0, "br_notTaken");
    applyStimulus(8, 0, 0, 4'd13, 3'd0, 16'h0055, 16'h0000, 5'd0, 0, "jump");

    applyStimulus(8, 1, 0, 4'd1, 3'd0, 16'h00FF, 16'h00FF, 5'd0, 0, "mulh_ff");
    expectPlan(8, "mulh_ff", 64'hFE, 1'b0);
    applyStimulus(8, 1, 0, 4'd0, 3'd0, 16'h00FF, 16'h00FF, 5'd0, 0, "mull_ff");
    expectPlan(8, "mull_ff", 64'h01, 1'b0);
    applyStimulus(8, 1, 0, 4'd2, 3'd0, 16'd200, 16'd7, 5'd0, 0, "divu_200_7");
    expectPlan(8, "divu_200_7", 64'd28, 1'b0);
    applyStimulus(8, 1, 0, 4'd3, 3'd0, 16'd200, 16'd7, 5'd0, 0, "remu_200_7");
    expectPlan(8, "remu_200_7", 64'd4, 1'b0);
    applyStimulus(8, 1, 0, 4'd2, 3'd0, 16'h0035, 16'h0000, 5'd0, 0, "divu_byZero");
    expectPlan(8, "divu_byZero", 64'hFF, 1'b1);
    launch(8, 1, 0, 4'd3, 3'd0, 16'h0035, 16'h0000, 5'd0, 0, 1'b1);
    awaitResult(8, "remu_byZero_held");
    expectPlan(8, "remu_byZero_held", 64'h35, 1'b1);
    checkQuiet(8, 12, "held_valid_singleOp");

    // Abort a multiply mid-iteration with an asynchronous reset.
    launch(8, 1, 0, 4'd0, 3'd0, 16'h005A, 16'h003C, 5'd0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    expectEq("abort_rslt",  obsRslt(8), 64'd0);
    expectEq("abort_flags", 64'(obsFlags(8)), 64'b001010);
    expSc[0] = 1'b0;
    expSc[1] = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    checkQuiet(8, 12, "abort_noValid");
    applyStimulus(8, 1, 0, 4'd0, 3'd0, 16'h005A, 16'h003C, 5'd0, 0, "after_abort_mull");

    applyStimulus(16, 0, 1, 4'd0, 3'd1, 16'h0000, 16'h0000, 5'd1, 0, "w16_subi");
    expectPlan(16, "w16_subi", 64'hFFFF, 1'b1);
    applyStimulus(16, 0, 0, 4'd2, 3'd0, 16'h1234, 16'h00FF, 5'd0, 1, "w16_and_clr");
    applyStimulus(16, 0, 1, 4'd0, 3'd1, 16'h0000, 16'h0000, 5'd1, 1, "w16_subi_clr");
    expectPlan(16, "w16_subi_clr", 64'hFFFF, 1'b0);
    applyStimulus(16, 1, 0, 4'd1, 3'd0, 16'hFFFF, 16'hFFFF, 5'd0, 0, "w16_mulh");
    applyStimulus(16, 1, 0, 4'd2, 3'd0, 16'd60000, 16'd123, 5'd0, 0, "w16_divu");

    for (int n = 0; n < 85; n++) begin
      logic [15:0] a, b;
      w   = (n < 60) ? 8 : 16;
      ext = ($urandom_range(0, 3) == 0);
      a   = 16'($urandom);
      b   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, w + 2)) : 16'($urandom);
      applyStimulus(w, ext, 1'($urandom_range(0, 1)),
                    ext ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), a, b, 5'($urandom),
                    ($urandom_range(0, 7) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
